// File: rtl/pattern_sequencer_pkg.sv
// Shared RGB565 colour constants and pattern-index encodings for the
// pattern sequencer and its lookup table.
package pattern_sequencer_pkg;

  // RGB565 layout: {r[4:0], g[5:0], b[4:0]}
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLUE  = 16'h001F;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BLACK = 16'h0000;

  typedef enum logic [1:0] {
    PAT_CHECKER  = 2'd0,
    PAT_STRIPES  = 2'd1,
    PAT_SOLID    = 2'd2,
    PAT_GRADIENT = 2'd3
  } pattern_e;

endpackage

// File: rtl/pattern_rom.sv
// Combinational test-pattern lookup: maps a pixel coordinate and pattern
// index to an RGB565 colour.
module pattern_rom
  import pattern_sequencer_pkg::*;
(
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [1:0]  idx,
  output logic [15:0] color
);

  // Low coordinate bits do not influence any pattern.
  logic unused_bits;
  assign unused_bits = ^{x[2:0], y[0]};

  // Select the colour for the current pixel of the requested pattern.
  always_comb begin
    color = BLACK;
    case (pattern_e'(idx))
      PAT_CHECKER:  color = (x[3] ^ y[2]) ? GREEN : BLUE;
      PAT_STRIPES:  color = x[3] ? GREEN : RED;
      PAT_SOLID:    color = WHITE;
      PAT_GRADIENT: color = {x[7:3], y[6:1], ~x[7:3]};
      default:      color = BLACK;
    endcase
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Test-pattern sequencer feeding an ST7735 driver: detects frame starts
// from the pixel scan, dwells on each pattern for a number of frames,
// accepts manual advance requests, and registers the pixel colour.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int unsigned DWELL_FRAMES = 60,
  parameter int unsigned NUM_PATTERNS = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic        pause,
  input  logic        next_req,
  output logic [15:0] color,
  output logic [1:0]  pattern_idx,
  output logic        frame_tick
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_FRAMES - 1);
  localparam logic [1:0] IDX_LAST   = 2'(NUM_PATTERNS - 1);

  logic [7:0]  prev_x;
  logic [6:0]  prev_y;
  logic [7:0]  dwell_cnt;
  logic [1:0]  idx_q;
  logic        pending;

  logic        frame_start;
  logic        consume_req;
  logic        dwell_expire;
  logic        advance;
  logic [1:0]  idx_next;
  logic [15:0] rom_color;

  pattern_rom u_rom (
    .x     (x),
    .y     (y),
    .idx   (idx_q),
    .color (rom_color)
  );

  // Frame-start detection and advance decision for this cycle.
  // A request arriving in the frame-start cycle itself is folded in here so
  // it is consumed immediately rather than left pending.
  always_comb begin
    frame_start  = (x == '0) && (y == '0) && !((prev_x == '0) && (prev_y == '0));
    consume_req  = pending || next_req;
    dwell_expire = !pause && (dwell_cnt == DWELL_LAST);
    advance      = frame_start && (consume_req || dwell_expire);
    idx_next     = (idx_q == IDX_LAST) ? '0 : idx_q + 2'd1;
  end

  // Coordinate history, frame tick and registered pixel colour.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_x     <= '0;
      prev_y     <= '0;
      frame_tick <= 1'b0;
      color      <= BLACK;
    end else begin
      prev_x     <= x;
      prev_y     <= y;
      frame_tick <= frame_start;
      color      <= rom_color;
    end
  end

  // Dwell counter, pattern index and pending request; all update only at
  // frame starts so a pattern never changes mid-frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dwell_cnt <= '0;
      idx_q     <= '0;
      pending   <= 1'b0;
    end else if (frame_start) begin
      pending <= 1'b0;
      if (consume_req || dwell_expire) begin
        dwell_cnt <= '0;
      end else if (!pause) begin
        dwell_cnt <= dwell_cnt + 8'd1;
      end
      if (advance) begin
        idx_q <= idx_next;
      end
    end else if (next_req) begin
      pending <= 1'b1;
    end
  end

  assign pattern_idx = idx_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer using a reduced 16x4 frame scan.
module tb_pattern_sequencer;

  localparam int unsigned W = 16;
  localparam int unsigned H = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  x = '0;
  logic [6:0]  y = '0;
  logic        pause = 1'b0;
  logic        next_req = 1'b0;
  logic [15:0] color;
  logic [1:0]  pattern_idx;
  logic        frame_tick;

  pattern_sequencer #(
    .DWELL_FRAMES (3),
    .NUM_PATTERNS (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .x           (x),
    .y           (y),
    .pause       (pause),
    .next_req    (next_req),
    .color       (color),
    .pattern_idx (pattern_idx),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  int tick_count  = 0;

  typedef struct {
    int unsigned cyc;
    logic [15:0] val;
  } col_t;

  logic [1:0] idx_q[$];
  col_t       col_q[$];
  col_t       col_e;
  logic [1:0] idx_e;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: each frame_tick pops an expected index; timed colour
  // expectations are popped on the cycle they fall due.
  always @(negedge clk) begin
    if (frame_tick) begin
      tick_count++;
      if (idx_q.size() == 0) begin
        check("unexpected_frame_tick", 1, 0);
      end else begin
        idx_e = idx_q.pop_front();
        check("pattern_idx_at_tick", int'(pattern_idx), int'(idx_e));
      end
    end
    while (col_q.size() > 0 && col_q[0].cyc <= cyc) begin
      col_e = col_q.pop_front();
      check("color", int'(color), int'(col_e.val));
    end
  end

  task automatic step(input int xx, input int yy, input logic nr, input logic p);
    @(posedge clk);
    #1;
    x        = 8'(xx);
    y        = 7'(yy);
    next_req = nr;
    pause    = p;
  endtask

  task automatic expect_color(input logic [15:0] v);
    col_q.push_back('{cyc + 1, v});
  endtask

  // mode 0: no requests; 1: two pulses mid-frame; 2: pulse on first pixel
  task automatic sweep(input logic p, input int mode);
    for (int yy = 0; yy < int'(H); yy++) begin
      for (int xx = 0; xx < int'(W); xx++) begin
        int  pix;
        logic nr;
        pix = yy * int'(W) + xx;
        nr  = ((mode == 1) && (pix == 10 || pix == 30)) || ((mode == 2) && (pix == 0));
        step(xx, yy, nr, p);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn   = 1'b0;
    x        = '0;
    y        = '0;
    pause    = 1'b0;
    next_req = 1'b0;
    #3;
    check("reset_color", int'(color), 0);
    check("reset_pattern_idx", int'(pattern_idx), 0);
    check("reset_frame_tick", int'(frame_tick), 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    check("release_color", int'(color), 0);
    check("release_pattern_idx", int'(pattern_idx), 0);
  endtask

  task automatic drain(input string name);
    repeat (3) step(1, 0, 1'b0, 1'b0);
    check({name, "_idx_pending"}, idx_q.size(), 0);
    check({name, "_color_pending"}, col_q.size(), 0);
  endtask

  initial begin
    int t0;

    // Reset: coordinates held at the origin never produce a frame start.
    do_reset();
    t0 = tick_count;
    repeat (10) step(0, 0, 1'b0, 1'b0);
    check("no_tick_at_origin", tick_count - t0, 0);

    // Auto-advance every 3 frames with wrap 3 -> 0.
    do_reset();
    foreach (idx_q[i]) ;
    idx_q = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    for (int f = 0; f < 13; f++) sweep(1'b0, 0);
    drain("auto");

    // Pause held for 5 frame starts at dwell count 1, then advance 2 frames later.
    do_reset();
    idx_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    sweep(1'b0, 0);
    sweep(1'b0, 0);
    for (int f = 0; f < 5; f++) sweep(1'b1, 0);
    sweep(1'b0, 0);
    sweep(1'b0, 0);
    drain("pause");

    // Two requests in one frame give a single advance and restart the dwell.
    do_reset();
    idx_q = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    sweep(1'b0, 0);
    sweep(1'b0, 1);
    for (int f = 0; f < 4; f++) sweep(1'b0, 0);
    drain("manual");
    // Leave a request pending, then reset over it.
    step(5, 1, 1'b1, 1'b0);
    step(6, 1, 1'b0, 1'b0);

    // Request coincident with dwell expiry: single advance, not left pending.
    do_reset();
    idx_q = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    for (int f = 0; f < 7; f++) sweep(1'b0, (f == 3) ? 2 : 0);
    drain("coincident");

    // Colour lookup across all four patterns, one cycle after the coordinate.
    do_reset();
    step(8, 0, 1'b0, 1'b0);   expect_color(16'h07E0);
    step(0, 1, 1'b0, 1'b0);   expect_color(16'h001F);
    step(0, 4, 1'b0, 1'b0);   expect_color(16'h07E0);
    step(8, 4, 1'b0, 1'b0);   expect_color(16'h001F);
    idx_q.push_back(2'd1);
    step(0, 0, 1'b1, 1'b0);   expect_color(16'h001F);
    step(8, 0, 1'b0, 1'b0);   expect_color(16'h07E0);
    step(0, 5, 1'b0, 1'b0);   expect_color(16'hF800);
    idx_q.push_back(2'd2);
    step(0, 0, 1'b1, 1'b0);   expect_color(16'hF800);
    step(3, 3, 1'b0, 1'b0);   expect_color(16'hFFFF);
    idx_q.push_back(2'd3);
    step(0, 0, 1'b1, 1'b0);   expect_color(16'hFFFF);
    step(255, 127, 1'b0, 1'b0); expect_color(16'hFFE0);
    idx_q.push_back(2'd3);
    step(0, 0, 1'b0, 1'b0);   expect_color(16'h001F);
    step(16, 2, 1'b0, 1'b0);  expect_color(16'h103D);
    drain("color");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
